// File: rtl/dt_loader_if.sv
// Byte-stream link into the tree loader: one data byte with valid/ready handshake.
// Latency: none, wires only.
// Backpressure: a byte moves on any cycle with in_valid and in_ready both high.
interface dt_loader_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/dt_loader.sv
// Frame parser that fills the decisiontree node/feature RAMs and runs one tree evaluation per run command.
// Latency: RAM strobes and start_o one cycle after the accepting byte; result one cycle after y_valid_i is sampled.
// Backpressure: in_ready drops only during RUN; in_valid gaps mid-frame simply hold the parser in place.
module dt_loader #(
   parameter int DATA        = 8,
   parameter int STATE       = 8,
   parameter int RUN_TIMEOUT = 1023
) (
   input  logic                      clk,
   input  logic                      reset,
   dt_loader_if.slave                bus,
   output logic                      node_we_o,
   output logic [STATE-1:0]          node_addr_o,
   output logic [DATA+3*STATE:0]     node_wdata_o,
   output logic                      feat_we_o,
   output logic [STATE-1:0]          feat_addr_o,
   output logic [DATA-1:0]           feat_wdata_o,
   output logic                      start_o,
   input  logic [7:0]                y_i,
   input  logic                      y_valid_i,
   output logic [7:0]                result_o,
   output logic                      result_valid_o,
   output logic                      busy_o,
   output logic                      err_o
);
   // Run cycle counter is wide enough to reach RUN_TIMEOUT exactly.
   localparam int CW = $clog2(RUN_TIMEOUT + 1);

   typedef enum logic [2:0] {S_IDLE, S_NCOUNT, S_NREC, S_FCOUNT, S_FDATA, S_RUN} state_t;

   state_t           state, state_nx;
   logic             acc;
   logic [7:0]       cnt;        // N or M of the current frame
   logic [7:0]       idx;        // records/bytes already written in this frame
   logic [2:0]       byte_idx;   // byte position inside a 5-byte node record
   logic [CW-1:0]    run_cnt;    // RUN cycle number, 1 on the start_o cycle
   logic             rec_dec;
   logic [DATA-1:0]  rec_data;
   logic [STATE-1:0] rec_t;
   logic [STATE-1:0] rec_f;

   logic err_set, err_clr, node_wr, feat_wr, run_go, capture;

   assign bus.in_ready = (state != S_RUN);
   assign busy_o       = (state != S_IDLE);
   assign acc          = bus.in_valid && bus.in_ready;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   // Next-state decode and one-cycle action requests for the datapath.
   always_comb begin
      state_nx = state;
      err_set  = 1'b0;
      err_clr  = 1'b0;
      node_wr  = 1'b0;
      feat_wr  = 1'b0;
      run_go   = 1'b0;
      capture  = 1'b0;
      case (state)
         S_IDLE: if (acc) begin
            case (bus.in_data)
               8'h00:   err_clr = 1'b1;
               8'h01:   state_nx = S_NCOUNT;
               8'h02:   state_nx = S_FCOUNT;
               8'h03: begin
                  state_nx = S_RUN;
                  run_go   = 1'b1;
               end
               default: err_set = 1'b1;
            endcase
         end
         S_NCOUNT: if (acc) begin
            if (bus.in_data == 8'd0) begin
               err_set  = 1'b1;
               state_nx = S_IDLE;
            end else begin
               state_nx = S_NREC;
            end
         end
         S_NREC: if (acc && byte_idx == 3'd4) begin
            node_wr = 1'b1;
            if (idx + 8'd1 == cnt) state_nx = S_IDLE;
         end
         S_FCOUNT: if (acc) begin
            if (bus.in_data == 8'd0) begin
               err_set  = 1'b1;
               state_nx = S_IDLE;
            end else begin
               state_nx = S_FDATA;
            end
         end
         S_FDATA: if (acc) begin
            feat_wr = 1'b1;
            if (idx + 8'd1 == cnt) state_nx = S_IDLE;
         end
         S_RUN: begin
            // The tree's valid is stale for two cycles while it leaves AWAIT.
            if (run_cnt >= CW'(3) && y_valid_i) begin
               capture  = 1'b1;
               state_nx = S_IDLE;
            end else if (run_cnt == CW'(RUN_TIMEOUT)) begin
               err_set  = 1'b1;
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Datapath: frame counters, record assembly, registered strobes and sticky error.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt            <= '0;
         idx            <= '0;
         byte_idx       <= '0;
         run_cnt        <= '0;
         rec_dec        <= 1'b0;
         rec_data       <= '0;
         rec_t          <= '0;
         rec_f          <= '0;
         node_we_o      <= 1'b0;
         node_addr_o    <= '0;
         node_wdata_o   <= '0;
         feat_we_o      <= 1'b0;
         feat_addr_o    <= '0;
         feat_wdata_o   <= '0;
         start_o        <= 1'b0;
         result_o       <= '0;
         result_valid_o <= 1'b0;
         err_o          <= 1'b0;
      end else begin
         node_we_o      <= node_wr;
         feat_we_o      <= feat_wr;
         start_o        <= run_go;
         result_valid_o <= capture;
         if (capture) result_o <= y_i;
         if (err_clr)      err_o <= 1'b0;
         else if (err_set) err_o <= 1'b1;

         if ((state == S_NCOUNT || state == S_FCOUNT) && acc) begin
            cnt      <= bus.in_data;
            idx      <= '0;
            byte_idx <= '0;
         end

         if (state == S_NREC && acc) begin
            case (byte_idx)
               3'd0:    rec_dec  <= bus.in_data[0];
               3'd1:    rec_data <= bus.in_data;
               3'd2:    rec_t    <= bus.in_data;
               3'd3:    rec_f    <= bus.in_data;
               default: ;
            endcase
            byte_idx <= (byte_idx == 3'd4) ? 3'd0 : byte_idx + 3'd1;
         end

         // Addresses are 1-based so node 0 (AWAIT) is never overwritten.
         if (node_wr) begin
            node_addr_o  <= idx + 8'd1;
            node_wdata_o <= {rec_dec, rec_data, rec_t, rec_f, bus.in_data};
            idx          <= idx + 8'd1;
         end
         if (feat_wr) begin
            feat_addr_o  <= idx + 8'd1;
            feat_wdata_o <= bus.in_data;
            idx          <= idx + 8'd1;
         end

         if (run_go)              run_cnt <= CW'(1);
         else if (state == S_RUN) run_cnt <= run_cnt + CW'(1);
      end
   end
endmodule

// File: tb/tb_dt_loader.sv
// Bench for dt_loader: frame-level driver with a scoreboard of expected strobes/results.
// Expected events carry the cycle they must appear in; a negedge monitor pops and compares.
// Tree side is modelled by the run driver, which presents y_valid_i in chosen RUN cycles.
module tb_dt_loader;
   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  y_i = 8'h00;
   logic        y_valid_i = 1'b0;
   logic        node_we_o, feat_we_o, start_o, result_valid_o, busy_o, err_o;
   logic [7:0]  node_addr_o, feat_addr_o, feat_wdata_o, result_o;
   logic [32:0] node_wdata_o;

   dt_loader_if bus();

   dt_loader #(.DATA(8), .STATE(8), .RUN_TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .node_we_o(node_we_o), .node_addr_o(node_addr_o), .node_wdata_o(node_wdata_o),
      .feat_we_o(feat_we_o), .feat_addr_o(feat_addr_o), .feat_wdata_o(feat_wdata_o),
      .start_o(start_o), .y_i(y_i), .y_valid_i(y_valid_i),
      .result_o(result_o), .result_valid_o(result_valid_o),
      .busy_o(busy_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int cyc; logic [7:0] addr; logic [32:0] data; } wr_t;
   typedef struct { int cyc; logic [7:0] y; } res_t;

   wr_t  exp_node[$];
   wr_t  exp_feat[$];
   int   exp_start[$];
   res_t exp_res[$];

   int checks = 0;
   int failures = 0;

   logic       model_err = 1'b0;
   logic [7:0] model_res = 8'h00;
   logic [7:0] nb[$];
   logic [7:0] fb[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every DUT output event must match the head of its queue, in its cycle.
   always @(negedge clk) begin
      wr_t  w;
      res_t r;
      int   s;
      if (node_we_o) begin
         if (exp_node.size() == 0) check("node_we_unexpected", 64'd1, 64'd0);
         else begin
            w = exp_node.pop_front();
            check("node_we_cycle", 64'(cyc), 64'(w.cyc));
            check("node_addr", 64'(node_addr_o), 64'(w.addr));
            check("node_wdata", 64'(node_wdata_o), 64'(w.data));
         end
      end
      if (feat_we_o) begin
         if (exp_feat.size() == 0) check("feat_we_unexpected", 64'd1, 64'd0);
         else begin
            w = exp_feat.pop_front();
            check("feat_we_cycle", 64'(cyc), 64'(w.cyc));
            check("feat_addr", 64'(feat_addr_o), 64'(w.addr));
            check("feat_wdata", 64'(feat_wdata_o), 64'(w.data[7:0]));
         end
      end
      if (start_o) begin
         if (exp_start.size() == 0) check("start_unexpected", 64'd1, 64'd0);
         else begin
            s = exp_start.pop_front();
            check("start_cycle", 64'(cyc), 64'(s));
         end
      end
      if (result_valid_o) begin
         if (exp_res.size() == 0) check("result_unexpected", 64'd1, 64'd0);
         else begin
            r = exp_res.pop_front();
            check("result_cycle", 64'(cyc), 64'(r.cyc));
            check("result_value", 64'(result_o), 64'(r.y));
         end
      end
   end

   // Present one byte and return the edge index at which it was accepted.
   task automatic send_byte(input logic [7:0] b, output int acc);
      int waitc = 0;
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && waitc < 50) begin
         @(posedge clk); #1;
         waitc++;
      end
      if (!bus.in_ready) check("in_ready_wait_expired", 64'd0, 64'd1);
      @(posedge clk); #1;
      acc = cyc;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
   endtask

   task automatic gap(input int maxg);
      int n = $urandom_range(0, maxg);
      bus.in_data = 8'($urandom);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic check_idle(input string name);
      check({name, "_busy"}, 64'(busy_o), 64'd0);
      check({name, "_err"}, 64'(err_o), 64'(model_err));
   endtask

   // Node frame: n records taken from nb (5 bytes each); record k lands at address k.
   task automatic node_frame(input int n, input int maxg);
      int  a;
      wr_t w;
      send_byte(8'h01, a); gap(maxg);
      send_byte(8'(n), a);
      if (n == 0) model_err = 1'b1;
      for (int k = 0; k < n; k++) begin
         for (int j = 0; j < 5; j++) begin
            gap(maxg);
            send_byte(nb[5*k+j], a);
         end
         w.cyc  = a;
         w.addr = 8'(k + 1);
         w.data = {nb[5*k][0], nb[5*k+1], nb[5*k+2], nb[5*k+3], nb[5*k+4]};
         exp_node.push_back(w);
      end
      check_idle("node_frame_end");
   endtask

   // Feature frame: m bytes from fb; byte k lands at address k.
   task automatic feat_frame(input int m, input int maxg);
      int  a;
      wr_t w;
      send_byte(8'h02, a); gap(maxg);
      send_byte(8'(m), a);
      if (m == 0) model_err = 1'b1;
      for (int k = 0; k < m; k++) begin
         gap(maxg);
         send_byte(fb[k], a);
         w.cyc  = a;
         w.addr = 8'(k + 1);
         w.data = {25'd0, fb[k]};
         exp_feat.push_back(w);
      end
      check_idle("feat_frame_end");
   endtask

   // Run: tree raises y_valid_i in RUN cycles whose mask bit is set (RUN cycle 1 = start_o cycle).
   task automatic run_cmd(input logic [15:0] mask, input int yv);
      int         a, capr, endr;
      logic [7:0] yr [0:15];
      res_t       r;
      for (int i = 0; i < 16; i++) yr[i] = (yv >= 0) ? 8'(yv) : 8'($urandom);
      capr = 0;
      for (int i = 3; i <= TO; i++) if (mask[i] && capr == 0) capr = i;
      endr = (capr != 0) ? capr : TO;
      send_byte(8'h03, a);
      exp_start.push_back(a);
      if (capr != 0) begin
         r.cyc = a + capr;
         r.y   = yr[capr];
         exp_res.push_back(r);
         model_res = yr[capr];
      end else begin
         model_err = 1'b1;
      end
      for (int i = 1; i <= endr; i++) begin
         y_valid_i = mask[i];
         y_i       = yr[i];
         check("run_in_ready_low", 64'(bus.in_ready), 64'd0);
         @(posedge clk); #1;
      end
      y_valid_i = 1'b0;
      check("run_in_ready_back", 64'(bus.in_ready), 64'd1);
      check("run_result_hold", 64'(result_o), 64'(model_res));
      check_idle("run_end");
   endtask

   task automatic cmd_only(input logic [7:0] c);
      int a;
      send_byte(c, a);
      if (c == 8'h00) model_err = 1'b0;
      else            model_err = 1'b1;
      check("cmd_err", 64'(err_o), 64'(model_err));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      model_err = 1'b0;
      model_res = 8'h00;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      int a, n;
      bus.in_data  = 8'h00;
      bus.in_valid = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      do_reset();

      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_outputs", {node_we_o, feat_we_o, start_o, result_valid_o, busy_o, err_o}, 64'd0);
      check("rst_data", {node_addr_o, feat_addr_o, feat_wdata_o, result_o}, 64'd0);
      check("rst_node_wdata", 64'(node_wdata_o), 64'd0);

      nb = '{8'h01, 8'h05, 8'h01, 8'h02, 8'h07, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
      node_frame(2, 0);

      fb = '{8'h0A, 8'h14, 8'h1E};
      feat_frame(3, 3);

      run_cmd(16'h0010, 8'h2A);
      run_cmd(16'h0006, -1);

      cmd_only(8'h55);
      cmd_only(8'h00);
      node_frame(0, 0);
      cmd_only(8'h00);
      feat_frame(0, 1);
      cmd_only(8'h00);

      // Reset in the middle of a node record, after byte2.
      cmd_only(8'hC3);
      send_byte(8'h01, a); send_byte(8'h01, a);
      send_byte(8'h11, a); send_byte(8'h22, a); send_byte(8'h33, a);
      do_reset();
      check("midrst_busy", 64'(busy_o), 64'd0);
      check("midrst_err", 64'(err_o), 64'd0);
      check("midrst_result", 64'(result_o), 64'd0);
      nb.delete();
      for (int j = 0; j < 5; j++) nb.push_back(8'($urandom));
      node_frame(1, 1);

      for (int it = 0; it < 24; it++) begin
         case ($urandom_range(0, 5))
            0: begin
               n = $urandom_range(1, 4);
               nb.delete();
               for (int j = 0; j < 5 * n; j++) nb.push_back(8'($urandom_range(0, 255)));
               node_frame(n, 2);
            end
            1: begin
               n = $urandom_range(1, 6);
               fb.delete();
               for (int j = 0; j < n; j++) fb.push_back(8'($urandom_range(0, 3)));
               feat_frame(n, 2);
            end
            2: run_cmd(16'($urandom) & 16'($urandom), -1);
            3: cmd_only(8'($urandom_range(4, 255)));
            4: cmd_only(8'h00);
            default: run_cmd(16'(1 << $urandom_range(1, 10)), -1);
         endcase
         gap(2);
      end

      repeat (4) begin
         @(posedge clk); #1;
      end
      check("left_node", 64'(exp_node.size()), 64'd0);
      check("left_feat", 64'(exp_feat.size()), 64'd0);
      check("left_start", 64'(exp_start.size()), 64'd0);
      check("left_result", 64'(exp_res.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
